sdram_arbiter: RTL and testbench

- Two-port arbiter that shares the single sys_* request port of the SDRAM controller between two requesters.
  - Port 0: the UART-driven tester.
  - Port 1: a second client, e.g. a pattern generator or scrubber.
- Arbitrates, latches the winning command, drives the controller handshake to completion and routes the acknowledge and read data back to the winner.
- Sits between the requesters and the controller in top, on clk_100.

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arbiter_if.sv | 35 +++
 rtl/sdram_arb_rr.sv | 24 ++
 rtl/sdram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the two-port SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 22;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side port bundle and controller-side sys_* bundle for the SDRAM arbiter.
interface sdram_port_if #(
  parameter int unsigned ADDR_W = sdram_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = sdram_arb_pkg::DEF_DATA_W
) ();
  logic              write_rq;
  logic              read_rq;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  // master = requester, slave = arbiter
  modport master (output write_rq, read_rq, addr, wdata, input ack, rdata);
  modport slave  (input write_rq, read_rq, addr, wdata, output ack, rdata);
endinterface

interface sdram_sys_if #(
  parameter int unsigned ADDR_W = sdram_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = sdram_arb_pkg::DEF_DATA_W
) ();
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] sys_data_to_sdram;
  logic [DATA_W-1:0] sys_data_from_sdram;
  logic              sys_write_rq;
  logic              sys_read_rq;
  logic              sys_write_done;
  logic              sys_data_from_sdram_valid;

  // master = arbiter, slave = SDRAM controller
  modport master (output sys_addr, sys_data_to_sdram, sys_write_rq, sys_read_rq,
                  input sys_data_from_sdram, sys_write_done, sys_data_from_sdram_valid);
  modport slave  (input sys_addr, sys_data_to_sdram, sys_write_rq, sys_read_rq,
                  output sys_data_from_sdram, sys_write_done, sys_data_from_sdram_valid);
endinterface

// File: rtl/sdram_arb_rr.sv
// Two-way winner picker: round-robin on ties, or port 0 always wins when FIXED_PRIORITY.
module sdram_arb_rr
  import sdram_arb_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic [1:0] i_active,
  input  logic       i_last,
  output logic       o_win_c,
  output logic       o_valid_c
);

  assign o_valid_c = |i_active;

  always_comb begin
    o_win_c = PORT0;
    if (&i_active) begin
      o_win_c = FIXED_PRIORITY ? PORT0 : ~i_last;
    end else if (i_active[1]) begin
      o_win_c = PORT1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller sys_* port between two requesters (IDLE -> ISSUE -> GAP).
// Optional watchdog abort in ISSUE is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  sdram_port_if.slave  p0,
  sdram_port_if.slave  p1,
  sdram_sys_if.master  sys,
  output logic         timeout_err
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_wr, w_wr_nxt, r_rd, w_rd_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt, r_rdata1, w_rdata1_nxt;
  logic              r_op, w_op_nxt, r_win, w_win_nxt, r_last, w_last_nxt;
  logic [1:0]        r_ack, w_ack_nxt;

  logic [1:0]        w_active;
  logic              w_win, w_valid, w_rsp, w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_tout, w_tout_nxt;
`endif

  assign w_active = {p1.write_rq | p1.read_rq, p0.write_rq | p0.read_rq};

  sdram_arb_rr #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_rr (
    .i_active  (w_active),
    .i_last    (r_last),
    .o_win_c   (w_win),
    .o_valid_c (w_valid)
  );

  assign w_sel_wr    = (w_win == PORT1) ? p1.write_rq : p0.write_rq;
  assign w_sel_addr  = (w_win == PORT1) ? p1.addr     : p0.addr;
  assign w_sel_wdata = (w_win == PORT1) ? p1.wdata    : p0.wdata;

  // Only the response matching the latched op completes the command
  assign w_rsp = (r_op == OP_WRITE) ? sys.sys_write_done : sys.sys_data_from_sdram_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_nxt     = r_wr;
    w_rd_nxt     = r_rd;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_op_nxt     = r_op;
    w_win_nxt    = r_win;
    w_last_nxt   = r_last;
    w_ack_nxt    = 2'b00;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
`ifdef SDRAM_ARB_TIMEOUT_EN
    w_cnt_nxt    = r_cnt;
    w_tout_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt = ISSUE;
          w_win_nxt   = w_win;
          w_addr_nxt  = w_sel_addr;
          w_data_nxt  = w_sel_wdata;
          w_op_nxt    = w_sel_wr ? OP_WRITE : OP_READ;
          w_wr_nxt    = w_sel_wr;
          w_rd_nxt    = ~w_sel_wr;
`ifdef SDRAM_ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      ISSUE: begin
        if (w_rsp) begin
          w_wr_nxt         = 1'b0;
          w_rd_nxt         = 1'b0;
          w_ack_nxt[r_win] = 1'b1;
          w_last_nxt       = r_win;
          w_state_nxt      = GAP;
          if (r_op == OP_READ) begin
            if (r_win == PORT1) w_rdata1_nxt = sys.sys_data_from_sdram;
            else                w_rdata0_nxt = sys.sys_data_from_sdram;
          end
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_wr_nxt         = 1'b0;
          w_rd_nxt         = 1'b0;
          w_ack_nxt[r_win] = 1'b1;
          w_last_nxt       = r_win;
          w_tout_nxt       = 1'b1;
          w_state_nxt      = GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_op     <= OP_READ;
      r_win    <= PORT0;
      r_last   <= PORT1;
      r_ack    <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_tout   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_wr     <= w_wr_nxt;
      r_rd     <= w_rd_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_op     <= w_op_nxt;
      r_win    <= w_win_nxt;
      r_last   <= w_last_nxt;
      r_ack    <= w_ack_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_cnt    <= w_cnt_nxt;
      r_tout   <= w_tout_nxt;
`endif
    end
  end

  assign sys.sys_addr          = r_addr;
  assign sys.sys_data_to_sdram = r_data;
  assign sys.sys_write_rq      = r_wr;
  assign sys.sys_read_rq       = r_rd;
  assign p0.ack                = r_ack[0];
  assign p1.ack                = r_ack[1];
  assign p0.rdata              = r_rdata0;
  assign p1.rdata              = r_rdata1;

`ifdef SDRAM_ARB_TIMEOUT_EN
  assign timeout_err = r_tout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter driven with identical stimulus.
module tb_sdram_arbiter;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic reset;
  logic terr_a, terr_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sdram_port_if #(.ADDR_W(AW), .DATA_W(DW)) p0_a ();
  sdram_port_if #(.ADDR_W(AW), .DATA_W(DW)) p1_a ();
  sdram_sys_if  #(.ADDR_W(AW), .DATA_W(DW)) sys_a ();
  sdram_port_if #(.ADDR_W(AW), .DATA_W(DW)) p0_b ();
  sdram_port_if #(.ADDR_W(AW), .DATA_W(DW)) p1_b ();
  sdram_sys_if  #(.ADDR_W(AW), .DATA_W(DW)) sys_b ();

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(TO)) u_rr (
    .clk(clk), .reset(reset), .p0(p0_a), .p1(p1_a), .sys(sys_a), .timeout_err(terr_a)
  );

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(TO)) u_fp (
    .clk(clk), .reset(reset), .p0(p0_b), .p1(p1_b), .sys(sys_b), .timeout_err(terr_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_p0(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_a.write_rq = wr; p0_a.read_rq = rd; p0_a.addr = a; p0_a.wdata = d;
    p0_b.write_rq = wr; p0_b.read_rq = rd; p0_b.addr = a; p0_b.wdata = d;
  endtask

  task automatic drive_p1(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_a.write_rq = wr; p1_a.read_rq = rd; p1_a.addr = a; p1_a.wdata = d;
    p1_b.write_rq = wr; p1_b.read_rq = rd; p1_b.addr = a; p1_b.wdata = d;
  endtask

  task automatic drive_rsp(input logic done, input logic valid, input logic [DW-1:0] d);
    sys_a.sys_write_done = done; sys_a.sys_data_from_sdram_valid = valid; sys_a.sys_data_from_sdram = d;
    sys_b.sys_write_done = done; sys_b.sys_data_from_sdram_valid = valid; sys_b.sys_data_from_sdram = d;
  endtask

  initial begin
    reset = 1'b0;
    drive_p0(1'b0, 1'b0, '0, '0);
    drive_p1(1'b0, 1'b0, '0, '0);
    drive_rsp(1'b0, 1'b0, '0);
    repeat (3) tick();

    // Reset state
    check("rst_wr_rq",  32'(sys_a.sys_write_rq), 32'h0);
    check("rst_rd_rq",  32'(sys_a.sys_read_rq),  32'h0);
    check("rst_addr",   32'(sys_a.sys_addr),     32'h0);
    check("rst_data",   32'(sys_a.sys_data_to_sdram), 32'h0);
    check("rst_acks",   32'({p1_a.ack, p0_a.ack}), 32'h0);
    check("rst_rdata0", 32'(p0_a.rdata), 32'h0);
    check("rst_terr",   32'(terr_a), 32'h0);
    reset = 1'b1;
    tick();

    // Single write from port 0
    drive_p0(1'b1, 1'b0, 22'h00123, 16'hBEEF);
    tick();
    check("wr_rq_latency", 32'(sys_a.sys_write_rq), 32'h1);
    check("wr_no_rd_rq",   32'(sys_a.sys_read_rq),  32'h0);
    check("wr_addr",       32'(sys_a.sys_addr), 32'h00123);
    check("wr_data",       32'(sys_a.sys_data_to_sdram), 32'hBEEF);
    drive_p0(1'b1, 1'b0, 22'h2AAAA, 16'h1111);
    tick();
    check("wr_addr_stable", 32'(sys_a.sys_addr), 32'h00123);
    check("wr_data_stable", 32'(sys_a.sys_data_to_sdram), 32'hBEEF);
    check("wr_rq_held",     32'(sys_a.sys_write_rq), 32'h1);
    check("wr_no_early_ack", 32'(p0_a.ack), 32'h0);
    drive_rsp(1'b1, 1'b0, '0);
    tick();
    check("wr_p0_ack",   32'(p0_a.ack), 32'h1);
    check("wr_p1_noack", 32'(p1_a.ack), 32'h0);
    check("wr_gap_rq",   32'(sys_a.sys_write_rq), 32'h0);
    drive_rsp(1'b0, 1'b0, '0);
    drive_p0(1'b0, 1'b0, '0, '0);
    tick();
    check("wr_ack_once", 32'(p0_a.ack), 32'h0);
    check("wr_idle_rq",  32'(sys_a.sys_write_rq), 32'h0);

    // Read from port 1, with a non-matching write_done ignored
    drive_p1(1'b0, 1'b1, 22'h3FFFFF, 16'h0);
    tick();
    check("rd_rq",     32'(sys_a.sys_read_rq), 32'h1);
    check("rd_no_wr",  32'(sys_a.sys_write_rq), 32'h0);
    check("rd_addr",   32'(sys_a.sys_addr), 32'h3FFFFF);
    drive_rsp(1'b1, 1'b0, 16'h0);
    tick();
    check("rd_ignore_done_rq",  32'(sys_a.sys_read_rq), 32'h1);
    check("rd_ignore_done_ack", 32'(p1_a.ack), 32'h0);
    drive_rsp(1'b0, 1'b1, 16'hA55A);
    tick();
    check("rd_p1_ack",   32'(p1_a.ack), 32'h1);
    check("rd_p1_rdata", 32'(p1_a.rdata), 32'hA55A);
    check("rd_p0_noack", 32'(p0_a.ack), 32'h0);
    check("rd_gap_rq",   32'(sys_a.sys_read_rq), 32'h0);
    drive_rsp(1'b0, 1'b0, 16'h0);
    drive_p1(1'b0, 1'b0, '0, '0);
    tick();
    check("rd_rdata_hold", 32'(p1_a.rdata), 32'hA55A);
    check("rd_p0_rdata",   32'(p0_a.rdata), 32'h0);
    check("rd_fp_rdata",   32'(p1_b.rdata), 32'hA55A);

    // Contention: both ports write continuously for four commands
    drive_p0(1'b1, 1'b0, 22'h00010, 16'hAAAA);
    drive_p1(1'b1, 1'b0, 22'h00020, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_addr",  32'(sys_a.sys_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
      check("fp_addr",  32'(sys_b.sys_addr), 32'h10);
      check("fp_data",  32'(sys_b.sys_data_to_sdram), 32'hAAAA);
      check("fp_wr_rq", 32'(sys_b.sys_write_rq), 32'h1);
      drive_rsp(1'b1, 1'b0, '0);
      tick();
      check("rr_p0_ack", 32'(p0_a.ack), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_p1_ack", 32'(p1_a.ack), (i % 2 == 1) ? 32'h1 : 32'h0);
      check("fp_p0_ack", 32'(p0_b.ack), 32'h1);
      check("fp_p1_ack", 32'(p1_b.ack), 32'h0);
      drive_rsp(1'b0, 1'b0, '0);
      tick();
    end
    drive_p0(1'b0, 1'b0, '0, '0);
    drive_p1(1'b0, 1'b0, '0, '0);
    tick();

    // Reset in the middle of a port 0 read
    drive_p0(1'b0, 1'b1, 22'h00055, 16'h0);
    tick();
    check("rst_mid_rq_before", 32'(sys_a.sys_read_rq), 32'h1);
    reset = 1'b0;
    drive_rsp(1'b0, 1'b1, 16'h1234);
    tick();
    check("rst_mid_rq_dropped", 32'(sys_a.sys_read_rq), 32'h0);
    check("rst_mid_no_ack",     32'(p0_a.ack), 32'h0);
    check("rst_mid_p1_rdata",   32'(p1_a.rdata), 32'h0);
    reset = 1'b1;
    drive_p0(1'b0, 1'b0, '0, '0);
    tick();
    check("rst_mid_still_no_ack", 32'(p0_a.ack), 32'h0);
    check("rst_mid_rdata",        32'(p0_a.rdata), 32'h0);
    check("rst_mid_idle_rq",      32'(sys_a.sys_read_rq), 32'h0);
    drive_rsp(1'b0, 1'b0, '0);
    tick();

    // Silent controller on a port 0 read
    drive_p0(1'b0, 1'b1, 22'h00077, 16'h0);
    tick();
    check("to_rd_rq", 32'(sys_a.sys_read_rq), 32'h1);
`ifdef SDRAM_ARB_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      tick();
      check("to_waiting_ack",  32'(p0_a.ack), 32'h0);
      check("to_waiting_terr", 32'(terr_a), 32'h0);
      check("to_waiting_rq",   32'(sys_a.sys_read_rq), 32'h1);
    end
    tick();
    check("to_ack",      32'(p0_a.ack), 32'h1);
    check("to_terr",     32'(terr_a), 32'h1);
    check("to_terr_fp",  32'(terr_b), 32'h1);
    check("to_rq_drop",  32'(sys_a.sys_read_rq), 32'h0);
    check("to_rdata",    32'(p0_a.rdata), 32'h0);
    drive_p0(1'b0, 1'b0, '0, '0);
    tick();
    check("to_ack_once",  32'(p0_a.ack), 32'h0);
    check("to_terr_once", 32'(terr_a), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nto_waiting_ack",  32'(p0_a.ack), 32'h0);
      check("nto_terr",         32'(terr_a), 32'h0);
      check("nto_terr_fp",      32'(terr_b), 32'h0);
      check("nto_waiting_rq",   32'(sys_a.sys_read_rq), 32'h1);
    end
    drive_rsp(1'b0, 1'b1, 16'hC0DE);
    tick();
    check("nto_ack",   32'(p0_a.ack), 32'h1);
    check("nto_rdata", 32'(p0_a.rdata), 32'hC0DE);
    check("nto_fp_rdata", 32'(p0_b.rdata), 32'hC0DE);
    drive_rsp(1'b0, 1'b0, '0);
    drive_p0(1'b0, 1'b0, '0, '0);
    tick();
    check("nto_ack_once", 32'(p0_a.ack), 32'h0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
